// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS fetch front end: fetch FSM state encoding,
// default instruction width, default reset PC and the NOP encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int          INSTR_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE = 2'd0;
    localparam fetch_state_t S_REQ  = 2'd1;
    localparam fetch_state_t S_HOLD = 2'd2;
    localparam fetch_state_t S_ERR  = 2'd3;

endpackage : mips_pkg

// File: rtl/fetch_watchdog.sv
// ---------------------------------------------------------------------------
// fetch_watchdog
// Down-counter watchdog for outstanding instruction fetches. Loaded with
// LIMIT whenever clear is high, decremented on every start cycle. expired
// fires combinationally on the LIMIT-th consecutive start cycle, so the
// owner can leave its waiting state on that same edge.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   count this cycle (request outstanding, no ack)
//   clear    in   reload the counter (ack seen or not requesting)
//   expired  out  LIMIT consecutive start cycles reached
// ---------------------------------------------------------------------------
module fetch_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int               CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (start && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q == 1 while start is high means this is the LIMIT-th waiting cycle.
    assign expired = start && (cnt_q == ONE);

endmodule : fetch_watchdog

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
// Instruction fetch sequencer for the MIPS pipeline. Owns the PC, drives the
// instruction-memory request handshake and produces the load strobe, data and
// PC for the IF/ID instruction register. Honours hazard stalls and branch
// flush/redirect.
//
// Optional feature: define FETCH_TIMEOUT_EN to add a fetch watchdog that
// moves the FSM to S_ERR and raises fetch_error after TIMEOUT_CYCLES
// consecutive unacknowledged request cycles. Without it fetch_error is 0 and
// S_ERR is unreachable.
//
// State table:
//   S_IDLE | out of reset, first fetch starts on the next clock
//   S_REQ  | request outstanding at imem_addr, waiting for imem_ack
//   S_HOLD | fetched word parked in hold buffer while stall is high
//   S_ERR  | watchdog expired; requests stop until reset
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   imem_req       out  fetch request to instruction memory
//   imem_addr      out  fetch address, stable until acknowledged
//   imem_ack       in   imem_rdata valid this cycle
//   imem_rdata     in   fetched instruction
//   stall          in   do not load IF/ID
//   flush          in   discard fetched/held instruction and redirect
//   branch_target  in   redirect address (bits [1:0] ignored)
//   ir_load        out  one-cycle IF/ID load strobe
//   ir_data        out  instruction presented to IF/ID
//   ir_pc          out  PC of ir_data
//   ir_valid       out  IF/ID holds a valid instruction
//   fetch_error    out  sticky watchdog error
// ---------------------------------------------------------------------------
module fetch_controller #(
    parameter int                ADDR_W         = 32,
    parameter int                INSTR_W        = mips_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(mips_pkg::RESET_PC),
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               ir_load,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    output logic               fetch_error
);

    import mips_pkg::*;

    fetch_state_t       state_q, state_d;
    // pc_q is the address of the next request; addr_q is the address of the
    // request currently on the bus. They differ only after a flush that had
    // to wait for the outstanding ack.
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               kill_q, kill_d;
    logic [INSTR_W-1:0] hold_data_q, hold_data_d;
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
    logic               ir_load_q, ir_load_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;

    logic [ADDR_W-1:0]  target_aligned;
    logic [ADDR_W-1:0]  pc_inc;
    logic               wd_expired;
    logic               unused_target_lsb;

    assign target_aligned    = {branch_target[ADDR_W-1:2], 2'b00};
    assign unused_target_lsb = ^branch_target[1:0];
    // Natural unsigned wrap gives FFFF_FFFC + 4 = 0.
    assign pc_inc            = addr_q + ADDR_W'(4);

`ifdef FETCH_TIMEOUT_EN
    logic wd_start;
    logic wd_clear;

    assign wd_start = (state_q == S_REQ) && !imem_ack;
    assign wd_clear = (state_q != S_REQ) || imem_ack;

    fetch_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_fetch_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (wd_start),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    assign fetch_error = (state_q == S_ERR);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wd_expired         = 1'b0;
    assign fetch_error        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        kill_d      = kill_q;
        hold_data_d = hold_data_q;
        hold_pc_d   = hold_pc_q;
        ir_load_d   = 1'b0;
        ir_data_d   = ir_data_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                addr_d  = pc_q;
            end

            S_REQ: begin
                if (flush) begin
                    pc_d = target_aligned;
                    if (imem_ack) begin
                        kill_d = 1'b0;
                        addr_d = target_aligned;
                    end else begin
                        // Request cannot be withdrawn: keep the old address
                        // on the bus and drop its data when it arrives.
                        kill_d = 1'b1;
                        if (wd_expired) begin
                            state_d = S_ERR;
                        end
                    end
                end else if (imem_ack) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                        addr_d = pc_q;
                    end else if (!stall) begin
                        ir_load_d  = 1'b1;
                        ir_data_d  = imem_rdata;
                        ir_pc_d    = addr_q;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_inc;
                        addr_d     = pc_inc;
                    end else begin
                        hold_data_d = imem_rdata;
                        hold_pc_d   = addr_q;
                        pc_d        = pc_inc;
                        addr_d      = pc_inc;
                        state_d     = S_HOLD;
                    end
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    pc_d    = target_aligned;
                    addr_d  = target_aligned;
                    state_d = S_REQ;
                end else if (!stall) begin
                    ir_load_d  = 1'b1;
                    ir_data_d  = hold_data_q;
                    ir_pc_d    = hold_pc_q;
                    ir_valid_d = 1'b1;
                    addr_d     = pc_q;
                    state_d    = S_REQ;
                end
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // No path loads IF/ID in a flush cycle, so this never masks a load.
        if (flush) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= '0;
            kill_q      <= 1'b0;
            hold_data_q <= INSTR_W'(NOP);
            hold_pc_q   <= '0;
            ir_load_q   <= 1'b0;
            ir_data_q   <= INSTR_W'(NOP);
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            kill_q      <= kill_d;
            hold_data_q <= hold_data_d;
            hold_pc_q   <= hold_pc_d;
            ir_load_q   <= ir_load_d;
            ir_data_q   <= ir_data_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = addr_q;
    assign ir_load   = ir_load_q;
    assign ir_data   = ir_data_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;

endmodule : fetch_controller

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch for the MIPS pipeline. Drives the instruction-memory request handshake, owns the PC, and generates the `load` strobe and data for the `instruction_register` (IF/ID). Honours stall requests from the hazard unit and flush/redirect requests from branch resolution. Sits between the PC/instruction memory and the IF/ID instruction register.

## Interface
- `ADDR_W`, 32, PC/address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `TIMEOUT_CYCLES`, 16, fetch watchdog limit; used only with `FETCH_TIMEOUT_EN`
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  ADDR_W  fetch address; stable while `imem_req`=1 and no `imem_ack`
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  INSTR_W  fetched instruction
- `stall`  in  1  hazard unit: do not load IF/ID
- `flush`  in  1  branch/jump taken: discard fetched/held instruction, redirect
- `branch_target`  in  ADDR_W  redirect address; bits [1:0] ignored and forced to 00
- `ir_load`  out  1  one-cycle load strobe to `instruction_register.load`
- `ir_data`  out  INSTR_W  value presented to `instruction_register.instruction_in`
- `ir_pc`  out  ADDR_W  PC of the instruction in `ir_data`
- `ir_valid`  out  1  IF/ID holds a valid (non-flushed) instruction
- `fetch_error`  out  1  sticky watchdog error; tied 0 without `FETCH_TIMEOUT_EN`

## Operation
- FSM states: `S_IDLE`, `S_REQ`, `S_HOLD`, `S_ERR`.
- Reset (async): state `S_IDLE`; internal `pc`=`RESET_PC`; all outputs 0 (`imem_addr`=0, `ir_pc`=0); kill flag cleared.
- `S_IDLE` moves to `S_REQ` on the first clock after `reset_n` rises.
- `S_REQ`: `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack` with kill flag set, or `flush`=1: discard data, clear kill, `pc`<=`branch_target` if `flush`, stay in `S_REQ`.
  - On `imem_ack`, `stall`=0: registered `ir_load`=1, `ir_data`=rdata, `ir_pc`=`pc`, `ir_valid`=1, `pc`<=`pc`+4, stay.
  - On `imem_ack`, `stall`=1: capture rdata/`pc` into hold buffer, `pc`<=`pc`+4, go to `S_HOLD`.
  - On `flush` without ack: the request cannot be withdrawn. Set kill, latch `branch_target` into `pc`, and keep `imem_addr` at the old address until ack. The next request uses the new `pc`.
- `S_HOLD`: `imem_req`=0.
  - `flush`: drop buffer, `pc`<=`branch_target`, go to `S_REQ`.
  - Else `stall`=0: `ir_load` pulse with buffered data, go to `S_REQ`.
- `flush` always beats `stall` and `imem_ack`. Any flush clears `ir_valid` on the next cycle unless the same cycle also produces an `ir_load`, which it cannot.
- `pc`+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC → 32'h0).
- `S_ERR`: `imem_req`=0, `fetch_error`=1, `ir_load`=0. The only exit is reset.

## Timing
- Request to IR: ack sampled at edge N → `ir_load`/`ir_data` valid during cycle N+1 → IR captures at edge N+2.
- Back-to-back fetches: with zero-wait memory, one `ir_load` every cycle. `imem_req` stays high and `imem_addr` advances each cycle.
- Stall release: `stall` falls before edge N → `ir_load` during cycle N+1, `imem_req` reasserted in cycle N+1.
- Flush: `flush` at edge N → `ir_valid`=0 in cycle N+1. The first redirected request goes out in cycle N+1, or in the cycle after the killed ack.
- Reset mid-fetch: outputs drop to reset values immediately, and any pending ack is ignored.

## Configuration
- `FETCH_TIMEOUT_EN` defined: a watchdog counts consecutive `S_REQ` cycles without `imem_ack`. Counting restarts on every ack. When the count reaches `TIMEOUT_CYCLES`, the FSM enters `S_ERR` and sets `fetch_error`.
- Not defined: no counter, `S_REQ` waits indefinitely, `S_ERR` is unreachable, and `fetch_error` is constant 0.

## Structure
- Shared package `mips_pkg`: FSM state typedef/encoding, `INSTR_W`, `RESET_PC` default, and the `NOP` constant (32'h0000_0000).
- One sub-module, `fetch_watchdog` (counter plus compare, `start`/`clear`/`expired`), instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- Reset release, memory ack every cycle with data 32'h12345678, 32'hAABBCCDD → `imem_addr` 0,4,8; `ir_load` pulses with `ir_pc` 0,4; `ir_valid`=1.
- Ack with `stall`=1 for 3 cycles, data 32'h12345678 → no `ir_load` and `imem_req`=0 while stalled; one `ir_load` with 32'h12345678 the cycle after the stall drops.
- `flush`=1, `branch_target`=32'h0000_0103 while a request waits, ack 2 cycles later → returned data discarded, next `imem_addr`=32'h0000_0100, `ir_valid`=0.
- `flush` and `stall` together in `S_HOLD` → buffer dropped, no `ir_load`, fetch resumes at the target.
- PC at 32'hFFFF_FFFC, ack → next `imem_addr`=32'h0.
- `FETCH_TIMEOUT_EN`, no ack for 16 cycles → `fetch_error`=1 and `imem_req`=0 until `reset_n` pulses low. Without the macro → still requesting, `fetch_error`=0.
